// File: rtl/regfile_sched_pkg.sv
// Shared types and default sizes for the register-file write scheduler.
package regfile_sched_pkg;

  typedef enum logic {
    INIT,
    RUN
  } sched_state_e;

  localparam int NUM_REGS_DEF = 11;
  localparam int DATA_W_DEF   = 24;
  localparam int ADDR_W_DEF   = 4;

  // r11 is sourced outside the register file and is never writable here.
  localparam logic [3:0] R_EXT_ADDR = 4'd11;

endpackage

// File: rtl/regfile_write_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, with wrap-around.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] idx;
  int            pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    pos       = 0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N) begin
        pos = pos - N;
      end
      idx = IW'(pos);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/regfile_write_sched.sv
// Write-port scheduler: clear sweep after reset/init_req, then round-robin write arbitration.
// Define RF_FIXED_PRIO_EN to give requester 0 absolute priority over the others.
module regfile_write_sched
  import regfile_sched_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic                       init_req,
  output logic                       init_busy,
  output logic                       rf_rst,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic                       err_addr,
  output logic [$clog2(NUM_REQ)-1:0] err_id
);

  localparam int                IDX_W     = $clog2(NUM_REQ);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              rf_rst_q, rf_rst_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              err_addr_q, err_addr_d;
  logic [IDX_W-1:0]  err_id_q, err_id_d;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               xfer;

`ifdef RF_FIXED_PRIO_EN
  // With requester 0 valid only it competes; otherwise bit 0 is already clear.
  assign arb_req = req_valid[0] ? NUM_REQ'(1) : req_valid;
`else
  assign arb_req = req_valid;
`endif

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (arb_req),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = (state_q == RUN && !init_req) ? grant : '0;
  assign xfer      = |req_ready;
  assign init_busy = (state_q == INIT);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rr_ptr_d   = rr_ptr_q;
    rf_rst_d   = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    err_addr_d = 1'b0;
    err_id_d   = err_id_q;
    case (state_q)
      INIT: begin
        if (init_req) begin
          ptr_d      = '0;
          rf_rst_d   = 1'b1;
          rf_waddr_d = '0;
        end else if (ptr_q == LAST_ADDR) begin
          state_d = RUN;
          ptr_d   = '0;
        end else begin
          ptr_d      = ptr_q + 1'b1;
          rf_rst_d   = 1'b1;
          rf_waddr_d = ptr_q + 1'b1;
        end
      end
      RUN: begin
        if (init_req) begin
          state_d    = INIT;
          ptr_d      = '0;
          rf_rst_d   = 1'b1;
          rf_waddr_d = '0;
        end else if (xfer) begin
          rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
          // Illegal targets are consumed but never reach the write port.
          if (sel_addr <= LAST_ADDR) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = sel_addr;
            rf_wdata_d = sel_data;
          end else begin
            err_addr_d = 1'b1;
            err_id_d   = grant_idx;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      ptr_q      <= '0;
      rr_ptr_q   <= '0;
      rf_rst_q   <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_addr_q <= 1'b0;
      err_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rr_ptr_q   <= rr_ptr_d;
      rf_rst_q   <= rf_rst_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_addr_q <= err_addr_d;
      err_id_q   <= err_id_d;
    end
  end

  assign rf_rst   = rf_rst_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign err_addr = err_addr_q;
  assign err_id   = err_id_q;

endmodule
